// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and sends it MSB-first,
// repeated reps+1 times with GAP idle cycles between copies. Outputs are registered.
module serial_pattern_tx #(
  parameter int   WIDTH    = 8,
  parameter int   REP_W    = 4,
  parameter int   GAP      = 2,
  parameter logic IDLE_BIT = 1'b1,
  parameter int   LEN_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             y,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [IDX_W-1:0] last_idx;   // eff_len-1, the reload value for each copy
  logic [IDX_W-1:0] bit_idx;
  logic [REP_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_cnt;

  logic [LEN_W-1:0] len_clamp;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] next_idx;

  assign len_clamp = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  assign start_idx = IDX_W'(len_clamp - LEN_W'(1));
  assign next_idx  = bit_idx - IDX_W'(1);

  // Outputs are loaded with the value the next state will present, so they
  // stay registered while still matching the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      pat_q    <= '0;
      last_idx <= '0;
      bit_idx  <= '0;
      rep_left <= '0;
      gap_cnt  <= '0;
      y        <= IDLE_BIT;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          y     <= IDLE_BIT;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start && len != '0) begin
            state    <= S_SHIFT;
            pat_q    <= pattern;
            last_idx <= start_idx;
            bit_idx  <= start_idx;
            rep_left <= reps;
            y        <= pattern[start_idx];
            valid    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bit_idx != '0) begin
            bit_idx <= next_idx;
            y       <= pat_q[next_idx];
          end else if (rep_left != '0) begin
            rep_left <= rep_left - REP_W'(1);
            bit_idx  <= last_idx;
            if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
              y       <= IDLE_BIT;
              valid   <= 1'b0;
            end else begin
              y <= pat_q[last_idx];
            end
          end else begin
            state <= S_DONE;
            y     <= IDLE_BIT;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_SHIFT;
            y     <= pat_q[bit_idx];
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          // DONE and any corrupted encoding fall back to IDLE
          state <= S_IDLE;
          y     <= IDLE_BIT;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a GAP=2 and a GAP=0 instance share inputs, each is
// compared cycle by cycle against an expected stream built from the transmit rules.
module tb_serial_pattern_tx;
  localparam int WIDTH = 8;
  localparam int REP_W = 4;
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam logic [3:0] IDLE_O = 4'b1000;  // {y,valid,busy,done}

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic y2, valid2, busy2, done2;
  logic y0, valid0, busy0, done0;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_s [2][256];
  int         exp_n [2];

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP(2), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .y(y2), .valid(valid2), .busy(busy2), .done(done2));

  serial_pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP(0), .IDLE_BIT(1'b1)) dut_b2b (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .y(y0), .valid(valid0), .busy(busy0), .done(done0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int d, input logic [3:0] exp);
    logic [3:0] act;
    act = (d == 0) ? {y2, valid2, busy2, done2} : {y0, valid0, busy0, done0};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s gap%0d t=%0t: y/valid/busy/done got %b, expected %b",
               name, (d == 0) ? 2 : 0, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs from the cycle after start, written from the
  // copy/gap/done description: copies of eff_len bits, gaps between, one done.
  task automatic build(input int d, input int gap, input logic [WIDTH-1:0] pat,
                       input logic [LEN_W-1:0] ln, input logic [REP_W-1:0] rp);
    int el;
    exp_n[d] = 0;
    el = (int'(ln) > WIDTH) ? WIDTH : int'(ln);
    if (el == 0) return;
    for (int c = 0; c <= int'(rp); c++) begin
      for (int i = el - 1; i >= 0; i--) exp_s[d][exp_n[d]++] = {pat[i], 3'b110};
      if (c < int'(rp))
        for (int g = 0; g < gap; g++) exp_s[d][exp_n[d]++] = 4'b1010;
    end
    exp_s[d][exp_n[d]++] = 4'b1001;
  endtask

  task automatic run_tx(input string name, input logic [WIDTH-1:0] pat,
                        input logic [LEN_W-1:0] ln, input logic [REP_W-1:0] rp,
                        input int poke_a, input int poke_b, input bit scramble,
                        output int nb2, output int nb0);
    int n;
    build(0, 2, pat, ln, rp);
    build(1, 0, pat, ln, rp);
    pattern = pat; len = ln; reps = rp; start = 1'b1;
    step();
    start = 1'b0;
    nb2 = 0; nb0 = 0;
    n = ((exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1]) + 2;
    for (int k = 1; k <= n; k++) begin
      for (int d = 0; d < 2; d++)
        check(name, d, (k <= exp_n[d]) ? exp_s[d][k-1] : IDLE_O);
      nb2 += int'(busy2);
      nb0 += int'(busy0);
      start = (k == poke_a || k == poke_b);
      if (scramble) begin
        pattern = WIDTH'($urandom);
        len     = LEN_W'($urandom_range(0, 9));
        reps    = REP_W'($urandom);
      end
      step();
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] ln;
    logic [REP_W-1:0] rp;
    int               busy2;  // expected busy cycles, GAP=2
    int               busy0;  // expected busy cycles, GAP=0
  } vec_t;

  initial begin
    vec_t vt[6];
    int nb2, nb0, el, lim, pa;
    logic [WIDTH-1:0] rpat;
    logic [LEN_W-1:0] rln;
    logic [REP_W-1:0] rrp;

    vt[0] = '{8'b1011_0010, 4'd8, 4'd0,  8,  8};
    vt[1] = '{8'b1010_0101, 4'd3, 4'd2, 13,  9};
    vt[2] = '{8'b1010_0101, 4'd9, 4'd1, 18, 16};
    vt[3] = '{8'b0011_1100, 4'd1, 4'd3, 10,  4};
    vt[4] = '{8'b1111_1110, 4'd2, 4'd15, 62, 32};
    vt[5] = '{8'b1000_0001, 4'd0, 4'd2,  0,  0};

    // reset held with start asserted
    reset = 1'b0; start = 1'b1; pattern = 8'b1011_0010; len = 4'd8; reps = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", 0, IDLE_O);
      check("reset_hold", 1, IDLE_O);
    end
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_release", 0, IDLE_O);
      check("reset_release", 1, IDLE_O);
    end

    foreach (vt[i]) begin
      run_tx($sformatf("vec%0d", i), vt[i].pat, vt[i].ln, vt[i].rp, -1, -1, 1'b0, nb2, nb0);
      check_int($sformatf("vec%0d_busy_gap2", i), nb2, vt[i].busy2);
      check_int($sformatf("vec%0d_busy_gap0", i), nb0, vt[i].busy0);
    end

    // extra start mid-stream and during DONE, inputs changing after acceptance
    run_tx("start_ignored", 8'b1011_0010, 4'd8, 4'd0, 4, 9, 1'b1, nb2, nb0);
    check_int("start_ignored_busy", nb2, 8);

    // reset while the 4th bit is on the line
    build(0, 2, 8'b1011_0010, 4'd8, 4'd0);
    pattern = 8'b1011_0010; len = 4'd8; reps = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("pre_reset", 0, exp_s[0][k-1]);
      check("pre_reset", 1, exp_s[0][k-1]);
      if (k == 4) reset = 1'b0;
      step();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_reset", 0, IDLE_O);
      check("mid_reset", 1, IDLE_O);
      step();
    end
    run_tx("after_reset", 8'b1011_0010, 4'd8, 4'd0, -1, -1, 1'b0, nb2, nb0);
    check_int("after_reset_busy", nb2, 8);

    // randomized transactions
    for (int it = 0; it < 40; it++) begin
      rpat = WIDTH'($urandom);
      rln  = LEN_W'($urandom_range(0, 9));
      rrp  = ($urandom_range(0, 7) == 0) ? REP_W'(15) : REP_W'($urandom_range(0, 3));
      el   = (int'(rln) > WIDTH) ? WIDTH : int'(rln);
      lim  = (int'(rrp) + 1) * el + 1;
      pa   = (el == 0) ? -1 : int'($urandom_range(1, lim));
      run_tx($sformatf("rand%0d", it), rpat, rln, rrp, pa, -1, 1'b1, nb2, nb0);
      check_int($sformatf("rand%0d_busy", it), nb2, (int'(rrp) + 1) * el + ((el == 0) ? 0 : int'(rrp) * 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
